// File: rtl/pulse_period_decoder.sv
// Recovers the load value of a terminal-count pulse stream from its edge-to-edge period,
// with lock detection on repeated equal measurements and a timeout on a stalled stream.
module pulse_period_decoder #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_i,
    output logic [WIDTH-1:0] value_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             err_o
);

    typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

    localparam logic [WIDTH:0] CntMax   = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] CntOne   = (WIDTH + 1)'(1);
    localparam logic [3:0]     LockThr  = 4'(LOCK_COUNT);
    localparam logic [3:0]     MatchMax = 4'd15;

    state_e           state_q, state_d;
    logic [WIDTH:0]   cnt_q, cnt_d;
    logic [3:0]       match_q, match_d;
    logic             pulse_q, pulse_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;

    logic             pulse_edge;
    logic [WIDTH:0]   meas;
    logic [WIDTH-1:0] meas_val;
    logic [3:0]       match_inc;

    assign pulse_edge = pulse_i & ~pulse_q;
    assign meas       = cnt_q - CntOne;
    assign meas_val   = meas[WIDTH-1:0];
    assign match_inc  = (match_q == MatchMax) ? MatchMax : match_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        match_d  = match_q;
        pulse_d  = pulse_i;
        value_d  = value_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                // First edge only starts the period count.
                if (pulse_edge) begin
                    cnt_d   = CntOne;
                    state_d = StMeasure;
                end
            end
            StMeasure, StLocked: begin
                cnt_d = cnt_q + CntOne;
                // An edge arriving at the full count still counts as a measurement.
                if (pulse_edge) begin
                    value_d  = meas_val;
                    valid_d  = 1'b1;
                    cnt_d    = CntOne;
                    match_d  = (meas_val == value_q && match_q != 4'd0) ? match_inc : 4'd1;
                    locked_d = (match_d >= LockThr);
                    state_d  = locked_d ? StLocked : StMeasure;
                end else if (cnt_q == CntMax) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    match_d  = 4'd0;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            match_q  <= 4'd0;
            pulse_q  <= 1'b0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            pulse_q  <= pulse_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign value_o  = value_q;
    assign valid_o  = valid_q;
    assign locked_o = locked_q;
    assign err_o    = err_q;

endmodule
